// File: rtl/dac_serializer.sv
// dac_serializer: paces the DDS with a one-clk sampling_pulse per frame,
// buffers the returned sample and shifts it out as a left-justified stereo
// stream (same word on both channels), MSB first.
// Optional feature macro: DAC_SER_UNDERRUN_EN enables the sticky underrun flag
// (missing DDS response detection); when undefined, underrun is tied low.
module dac_serializer #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                sampling_pulse,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                busy,
  output logic                underrun,
  input  logic                clear_underrun
);

  localparam int unsigned       SLOT_W     = $clog2(2 * SAMPLE_W);
  localparam logic [7:0]        DIV_LAST   = 8'(DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * SAMPLE_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_W);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [7:0]          div_q;
  logic [7:0]          div_d;
  logic                phase_q;
  logic                phase_d;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   slot_d;
  logic [SAMPLE_W-1:0] hold_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic                pulse_q;
  logic                bclk_q;
  logic                lrck_q;
  logic                sdata_q;
  logic                busy_q;

  logic                div_wrap_s;
  logic                slot_start_s;
  logic                frame_end_s;
  logic                frame_start_s;

  // Next counter position and frame boundary detection.
  always_comb begin
    div_wrap_s    = (div_q == DIV_LAST);
    // The next cycle opens a new slot (bclk falling edge).
    slot_start_s  = div_wrap_s && phase_q;
    frame_end_s   = slot_start_s && (slot_q == SLOT_LAST);
    // A frame starts when leaving IDLE or when RUN wraps with enable still set.
    frame_start_s = enable && ((state_q == ST_IDLE) ||
                              ((state_q == ST_RUN) && frame_end_s));
    if (div_wrap_s) begin
      div_d   = 8'd0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + 8'd1;
      phase_d = phase_q;
    end
    if (frame_end_s) begin
      slot_d = '0;
    end else if (slot_start_s) begin
      slot_d = slot_q + SLOT_W'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  // Run/idle FSM with counters, shift register and registered serial outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      slot_q  <= '0;
      shift_q <= '0;
      pulse_q <= 1'b0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (frame_start_s) begin
      // Load the word held before this edge; a coincident capture waits a frame.
      state_q <= ST_RUN;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      slot_q  <= '0;
      shift_q <= hold_q;
      pulse_q <= 1'b1;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= hold_q[SAMPLE_W-1];
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (frame_end_s) begin
            // Final frame finished with enable low: park everything low.
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            phase_q <= 1'b0;
            slot_q  <= '0;
            pulse_q <= 1'b0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            div_q   <= div_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            pulse_q <= 1'b0;
            bclk_q  <= phase_d;
            busy_q  <= 1'b1;
            if (slot_start_s) begin
              // Rotate so the right channel replays the same word after SAMPLE_W slots.
              shift_q <= {shift_q[SAMPLE_W-2:0], shift_q[SAMPLE_W-1]};
              sdata_q <= shift_q[SAMPLE_W-2];
              lrck_q  <= (slot_d >= SLOT_RIGHT);
            end else begin
              shift_q <= shift_q;
              sdata_q <= sdata_q;
              lrck_q  <= lrck_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          div_q   <= 8'd0;
          phase_q <= 1'b0;
          slot_q  <= '0;
          pulse_q <= 1'b0;
          bclk_q  <= 1'b0;
          lrck_q  <= 1'b0;
          sdata_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Hold register captures every DDS response, in IDLE as well as RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (new_sample_ready) begin
      hold_q <= sample;
    end else begin
      hold_q <= hold_q;
    end
  end

`ifdef DAC_SER_UNDERRUN_EN
  logic got_q;
  logic underrun_q;
  logic underrun_event_s;

  // Only a wrap inside RUN is checked; the first frame after IDLE has no prior request.
  assign underrun_event_s = enable && (state_q == ST_RUN) && frame_end_s &&
                            !(got_q || new_sample_ready);

  // Got flag: a response arrived since the last frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      got_q <= 1'b0;
    end else if (frame_start_s) begin
      got_q <= 1'b0;
    end else if (new_sample_ready) begin
      got_q <= 1'b1;
    end else begin
      got_q <= got_q;
    end
  end

  // Sticky underrun flag; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else if (underrun_event_s) begin
      underrun_q <= 1'b1;
    end else if (clear_underrun) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_q;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_clear_s;
  assign unused_clear_s = clear_underrun;
  assign underrun       = 1'b0;
`endif

  assign sampling_pulse = pulse_q;
  assign bclk           = bclk_q;
  assign lrck           = lrck_q;
  assign sdata          = sdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: frame-position reference model plus
// directed frames (0xA5C3, 0x8000, 0x7FFF, withheld response, enable drop,
// mid-frame reset) and randomized DDS response timing.
module tb_dac_serializer;

  localparam int DIV   = 4;
  localparam int W     = 16;
  localparam int FRAME = 4 * W * DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        new_sample_ready;
  logic        clear_underrun;
  logic [15:0] sample;
  logic        sampling_pulse;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        busy;
  logic        underrun;

  dac_serializer #(.DIV(DIV), .SAMPLE_W(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .sampling_pulse   (sampling_pulse),
    .new_sample_ready (new_sample_ready),
    .sample           (sample),
    .bclk             (bclk),
    .lrck             (lrck),
    .sdata            (sdata),
    .busy             (busy),
    .underrun         (underrun),
    .clear_underrun   (clear_underrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_cyc = 0;

  // Reference model: position inside the frame and the word being shown.
  bit          run_m      = 1'b0;
  int          t_m        = 0;
  logic [15:0] word_m     = 16'h0000;
  logic [15:0] hold_m     = 16'h0000;
  bit          got_m      = 1'b0;
  bit          underrun_m = 1'b0;

  // DDS responder plan: bit 16 set = withhold the response for that frame.
  logic [16:0] plan_q[$];
  bit          rand_mode = 1'b0;
  int          resp_t    = 1;
  bit          resp_skip = 1'b1;
  logic [15:0] resp_val  = 16'h0000;

  logic [31:0] cap       = 32'h0;
  logic [31:0] last_bits = 32'h0;
  logic        prev_bclk = 1'b0;
  bit          expect_ur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_vec();
    logic [5:0] v;
    int slot;
    if (!run_m) begin
      v = {5'b00000, underrun_m};
    end else begin
      slot = t_m / (2 * DIV);
      v = {(t_m == 0), (((t_m / DIV) % 2) == 1), (slot >= W),
           word_m[W - 1 - (slot % W)], 1'b1, underrun_m};
    end
    return v;
  endfunction

  task automatic model_reset();
    run_m      = 1'b0;
    t_m        = 0;
    hold_m     = 16'h0000;
    got_m      = 1'b0;
    underrun_m = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit nsr, input logic [15:0] smp, input bit clr);
    bit start = 1'b0;
    bit ev    = 1'b0;
    if (!run_m) begin
      if (en) begin
        run_m = 1'b1; t_m = 0; word_m = hold_m; start = 1'b1;
      end
    end else if (t_m == FRAME - 1) begin
      if (en) begin
        t_m = 0; word_m = hold_m; start = 1'b1; ev = !(got_m || nsr);
      end else begin
        run_m = 1'b0; t_m = 0;
      end
    end else begin
      t_m++;
    end
    got_m = start ? 1'b0 : (got_m || nsr);
    if (nsr) hold_m = smp;
`ifdef DAC_SER_UNDERRUN_EN
    if (ev) underrun_m = 1'b1;
    else if (clr) underrun_m = 1'b0;
`else
    if (ev && clr) underrun_m = 1'b0;
`endif
  endtask

  task automatic cycle();
    logic [16:0] p;
    if (reset_n && run_m && t_m == 0) begin
      if (plan_q.size() > 0) p = plan_q.pop_front();
      else p = {($urandom_range(0, 7) == 0), 16'($urandom)};
      resp_skip = p[16];
      resp_val  = p[15:0];
      resp_t    = rand_mode ? int'($urandom_range(1, FRAME - 1)) : 1;
    end
    new_sample_ready = reset_n && run_m && (t_m == resp_t) && !resp_skip;
    sample = new_sample_ready ? resp_val : 16'($urandom);
    if (rand_mode) clear_underrun = ($urandom_range(0, 63) == 0);
    @(posedge clk);
    if (reset_n) model_edge(enable, new_sample_ready, sample, clear_underrun);
    else model_reset();
    #1;
    cyc++;
    check("outputs", 32'({sampling_pulse, bclk, lrck, sdata, busy, underrun}), 32'(exp_vec()));
    if (sampling_pulse) begin
      last_bits = cap; cap = 32'h0; pulse_cyc = cyc;
    end
    if (bclk && !prev_bclk) cap = {cap[30:0], sdata};
    prev_bclk = bclk;
  endtask

  initial begin
`ifdef DAC_SER_UNDERRUN_EN
    expect_ur = 1'b1;
`else
    expect_ur = 1'b0;
`endif
    reset_n = 1'b0; enable = 1'b1; new_sample_ready = 1'b0;
    clear_underrun = 1'b0; sample = 16'h0000;
    repeat (3) cycle();
    check("reset_outputs", 32'({sampling_pulse, bclk, lrck, sdata, busy, underrun}), 32'h0);

    // Release: first pulse one clk later, then the directed frame sequence.
    plan_q.push_back({1'b0, 16'hA5C3});
    plan_q.push_back({1'b0, 16'h8000});
    plan_q.push_back({1'b0, 16'h7FFF});
    plan_q.push_back({1'b1, 16'h0000});
    reset_n = 1'b1;
    cycle();
    check("first_pulse", 32'(sampling_pulse), 32'h1);
    repeat (FRAME) cycle();
    check("frame0_bits", last_bits, 32'h0000_0000);
    repeat (FRAME) cycle();
    check("a5c3_bits", last_bits, 32'hA5C3_A5C3);
    repeat (FRAME) cycle();
    check("8000_bits", last_bits, 32'h8000_8000);
    repeat (FRAME) cycle();
    check("7fff_bits", last_bits, 32'h7FFF_7FFF);
    check("underrun_set", 32'(underrun), 32'(expect_ur));
    repeat (FRAME) cycle();
    check("replay_bits", last_bits, 32'h7FFF_7FFF);
    clear_underrun = 1'b1;
    cycle();
    clear_underrun = 1'b0;
    check("underrun_clear", 32'(underrun), 32'h0);

    // Randomized response values, timing, withholding and clears.
    rand_mode = 1'b1;
    repeat (8 * FRAME) cycle();
    rand_mode = 1'b0;
    clear_underrun = 1'b0;

    // Drop enable at slot 5; the frame must complete.
    for (int i = 0; i < 2 * FRAME && !(run_m && t_m == 40); i++) cycle();
    check("reach_slot5", 32'(t_m), 32'd40);
    enable = 1'b0;
    for (int i = 0; i < 2 * FRAME && busy === 1'b1; i++) cycle();
    check("busy_fall", 32'(cyc - pulse_cyc), 32'(FRAME));
    repeat (10) cycle();
    check("idle_outputs", 32'({sampling_pulse, bclk, lrck, sdata, busy}), 32'h0);

    // Restart, then asynchronous reset at slot 20.
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(run_m && t_m == 160); i++) cycle();
    check("reach_slot20", 32'(t_m), 32'd160);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 32'({sampling_pulse, bclk, lrck, sdata, busy, underrun}), 32'h0);
    repeat (3) cycle();
    reset_n = 1'b1;
    plan_q.push_back({1'b0, 16'h1234});
    repeat (2 * FRAME + 2) cycle();
    check("post_reset_bits", last_bits, 32'h1234_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
